// File: rtl/dut_stream_bridge_if.sv
// dut_stream_bridge_if: AXI-stream bundle (data, keep, last, valid, ready) with master/slave views
interface dut_stream_bridge_if #(
    parameter int W = 32
);
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;
    logic           tvalid;
    logic           tready;
    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dut_stream_bridge.sv
// dut_stream_bridge: DMA stream -> fixed-latency DUT -> buffered result stream with framing; DSB_SIGN_EXT_EN selects sign extension of results
module dut_stream_bridge #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int AXIS_W     = 32,
    parameter int DUT_LAT    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    dut_stream_bridge_if.slave   s_axis,
    output logic [IN_W-1:0]      dut_din,
    output logic                 dut_din_vld,
    input  logic [OUT_W-1:0]     dut_dout,
    dut_stream_bridge_if.master  m_axis,
    output logic                 busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              r_state, w_state_nxt;
    logic [AXIS_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_cnt, r_infl;
    logic [DUT_LAT-1:0]  r_dly;
    logic [BW-1:0]       r_beat;
    logic [IN_W-1:0]     r_din;
    logic                r_din_vld;
    logic                w_s_rdy, w_s_acc, w_m_acc, w_wr, w_we, w_empty, w_full, w_final, w_last;
    logic [AXIS_W-1:0]   w_ext;

`ifdef DSB_SIGN_EXT_EN
    assign w_ext = AXIS_W'($signed(dut_dout));
`else
    assign w_ext = AXIS_W'(dut_dout);
`endif

    // Credit: buffered plus in-flight samples never exceed the FIFO, so a write always finds room
    assign w_s_rdy = (r_state == RUN) && (({1'b0, r_cnt} + {1'b0, r_infl}) < (CW+1)'(FIFO_DEPTH));
    assign w_s_acc = s_axis.tvalid && w_s_rdy;
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_m_acc = !w_empty && m_axis.tready;
    assign w_wr    = r_dly[DUT_LAT-1];
    assign w_we    = w_wr && (!w_full || w_m_acc);
    assign w_final = (r_state == DRAIN) && (r_cnt == CW'(1)) && (r_infl == '0);
    assign w_last  = !w_empty && ((r_beat == BW'(FRAME_LEN - 1)) || w_final);

    assign s_axis.tready = w_s_rdy;
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign m_axis.tkeep  = '1;
    assign m_axis.tlast  = w_last;
    assign dut_din       = r_din;
    assign dut_din_vld   = r_din_vld;
    assign busy          = (r_state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: drain only finishes once nothing is in flight or buffered
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = enable ? RUN : IDLE;
            RUN:     w_state_nxt = enable ? RUN : DRAIN;
            DRAIN:   w_state_nxt = (r_infl == '0 && w_empty) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Register accepted sample and its one-cycle strobe toward the DUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din     <= '0;
            r_din_vld <= 1'b0;
        end else begin
            r_din_vld <= w_s_acc;
            if (w_s_acc) r_din <= s_axis.tdata[IN_W-1:0];
        end
    end

    // Strobe delay line matching DUT latency, plus count of samples not yet buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly  <= '0;
            r_infl <= '0;
        end else begin
            r_dly  <= DUT_LAT'({r_dly, r_din_vld});
            r_infl <= r_infl + CW'(w_s_acc) - CW'(w_wr);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= w_ext;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_we);
            r_rd_ptr <= r_rd_ptr + AW'(w_m_acc);
            r_cnt    <= r_cnt + CW'(w_we) - CW'(w_m_acc);
        end
    end

    // Output beat counter, cleared after every tlast beat
    always_ff @(posedge clk) begin
        if (rst)          r_beat <= '0;
        else if (w_m_acc) r_beat <= w_last ? '0 : r_beat + BW'(1);
    end
endmodule

// File: tb/tb_dut_stream_bridge.sv
// tb_dut_stream_bridge: directed + random stimulus against a queue-based reference model of the bridge
module tb_dut_stream_bridge;
    localparam int DUT_LAT    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_LEN  = 4;
`ifdef DSB_SIGN_EXT_EN
    localparam logic [31:0] EXP_SIGN = 32'hFFFF8000;
`else
    localparam logic [31:0] EXP_SIGN = 32'h00008000;
`endif

    typedef enum int {S_IDLE, S_RUN, S_DRAIN} mstate_t;
    typedef struct {logic [31:0] d; int rdy;} item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] dut_din;
    logic        dut_din_vld;
    logic [15:0] dut_dout;
    logic        busy;
    logic [15:0] pipe [DUT_LAT];

    dut_stream_bridge_if #(.W(32)) s_axis ();
    dut_stream_bridge_if #(.W(32)) m_axis ();

    int      total = 0, bad = 0, cyc = 0;
    int      n_in = 0, n_out = 0, n_last = 0, first_acc = -1, first_out = -1, fpos = 0;
    item_t   q[$];
    mstate_t st = S_IDLE;
    logic        prev_acc = 1'b0, prev_stall = 1'b0, prev_l = 1'b0;
    logic [15:0] prev_din = '0;
    logic [31:0] prev_d = '0;

    dut_stream_bridge #(
        .IN_W(16), .OUT_W(16), .AXIS_W(32), .DUT_LAT(DUT_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .s_axis(s_axis),
        .dut_din(dut_din), .dut_din_vld(dut_din_vld), .dut_dout(dut_dout),
        .m_axis(m_axis), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback DUT: identity function with DUT_LAT cycles of latency
    always @(posedge clk) begin
        pipe[0] <= dut_din;
        for (int i = 1; i < DUT_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dut_dout = pipe[DUT_LAT-1];

    function automatic logic [31:0] ext(input logic [15:0] x);
`ifdef DSB_SIGN_EXT_EN
        return {{16{x[15]}}, x};
`else
        return {16'h0000, x};
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every sample accepted is owed once on the output, in order,
    // no earlier than DUT_LAT+2 cycles after acceptance
    always @(negedge clk) begin : mon
        int   size0;
        logic acc, exp_v, exp_last;
        size0 = q.size();
        exp_v = 1'b0;
        if (size0 > 0) exp_v = (q[0].rdy <= cyc);
        chk("busy", busy, st != S_IDLE);
        chk("s_tready", s_axis.tready, (st == S_RUN) && (size0 < FIFO_DEPTH));
        chk("m_tvalid", m_axis.tvalid, exp_v);
        chk("din_vld", dut_din_vld, prev_acc);
        if (prev_acc) chk("din", dut_din, prev_din);
        if (prev_stall) begin
            chk("hold_valid", m_axis.tvalid, 1);
            chk("hold_data", m_axis.tdata, prev_d);
            chk("hold_last", m_axis.tlast, prev_l);
        end
        acc = s_axis.tvalid && s_axis.tready;
        if (acc) begin
            q.push_back('{ext(s_axis.tdata[15:0]), cyc + DUT_LAT + 2});
            n_in++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (m_axis.tvalid && first_out < 0) first_out = cyc;
        if (m_axis.tvalid && m_axis.tready) begin
            chk("beat_owed", size0 > 0, 1);
            if (size0 > 0) begin
                exp_last = (fpos == FRAME_LEN - 1) || (st == S_DRAIN && size0 == 1);
                chk("tdata", m_axis.tdata, q[0].d);
                chk("tlast", m_axis.tlast, exp_last);
                chk("tkeep", m_axis.tkeep, 4'hF);
                void'(q.pop_front());
                fpos = exp_last ? 0 : fpos + 1;
            end
            n_out++;
            if (m_axis.tlast) n_last++;
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_d     = m_axis.tdata;
        prev_l     = m_axis.tlast;
        prev_acc   = acc;
        prev_din   = s_axis.tdata[15:0];
        case (st)
            S_IDLE:  st = enable ? S_RUN : S_IDLE;
            S_RUN:   st = enable ? S_RUN : S_DRAIN;
            default: st = (size0 == 0) ? S_IDLE : S_DRAIN;
        endcase
        if (rst) begin
            q.delete();
            st = S_IDLE;
            fpos = 0;
            prev_acc = 1'b0;
            prev_stall = 1'b0;
        end
    end

    task automatic send_seq(input int n, input logic [31:0] base, input int budget);
        int k = 0, t = 0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = base;
        while (k < n && t < budget) begin
            @(negedge clk);
            t++;
            if (s_axis.tready) k++;
            @(posedge clk);
            #1;
            s_axis.tdata = base + k;
            if (k == n) s_axis.tvalid = 1'b0;
        end
        s_axis.tvalid = 1'b0;
        chk("send_count", k, n);
    endtask

    task automatic wait_flush(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (q.size() != 0 && t < budget);
        chk("flush_empty", q.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < budget);
        chk("idle_busy", busy, 0);
        chk("idle_empty", q.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base_out, acc_cnt, t;
        logic acc;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '1;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", m_axis.tvalid, 0);
        chk("rst_s_tready", s_axis.tready, 0);
        chk("rst_din_vld", dut_din_vld, 0);
        chk("rst_din", dut_din, 0);
        chk("rst_tlast", m_axis.tlast, 0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_busy", busy, 0);

        // Upstream valid while idle is never consumed
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h1234;
        repeat (5) @(negedge clk);
        chk("idle_tready", s_axis.tready, 0);
        chk("idle_no_strobe", n_in, 0);
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;

        // Eight beats with free-flowing output, first-beat latency
        first_acc = -1;
        first_out = -1;
        enable = 1'b1;
        m_axis.tready = 1'b1;
        send_seq(8, 32'h1, 100);
        wait_flush(50);
        chk("first_latency", first_out - first_acc, DUT_LAT + 2);
        chk("out_count_8", n_out, 8);

        // Backpressure: credit stops upstream after exactly FIFO_DEPTH accepts
        @(posedge clk);
        #1;
        m_axis.tready = 1'b0;
        base_out = n_out;
        acc_cnt = 0;
        s_axis.tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_axis.tdata = 32'hA000 + acc_cnt;
            @(negedge clk);
            if (s_axis.tready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        s_axis.tvalid = 1'b0;
        chk("credit_accepts", acc_cnt, FIFO_DEPTH);
        @(negedge clk);
        chk("credit_tready", s_axis.tready, 0);
        @(posedge clk);
        #1;
        m_axis.tready = 1'b1;
        wait_flush(100);
        chk("credit_out", n_out - base_out, FIFO_DEPTH);

        // Result extension of a negative value
        @(posedge clk);
        #1;
        m_axis.tready = 1'b0;
        send_seq(1, 32'hABCD8000, 50);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_axis.tvalid && t < 20);
        chk("ext_valid", m_axis.tvalid, 1);
        chk("ext_data", m_axis.tdata, EXP_SIGN);
        @(posedge clk);
        #1;
        m_axis.tready = 1'b1;
        wait_flush(20);

        // Framing: FRAME_LEN=4, 10 beats then drain -> tlast on 4, 8, 10
        @(posedge clk);
        #1;
        enable = 1'b0;
        pulse_rst();
        @(posedge clk);
        #1;
        enable = 1'b1;
        n_last = 0;
        base_out = n_out;
        send_seq(10, 32'h100, 100);
        enable = 1'b0;
        wait_idle(100);
        chk("frame_out", n_out - base_out, 10);
        chk("frame_tlasts", n_last, 3);

        // Reset with samples in flight and buffered, then restart framing
        @(posedge clk);
        #1;
        enable = 1'b1;
        m_axis.tready = 1'b0;
        send_seq(8, 32'h200, 100);
        @(posedge clk);
        #1;
        pulse_rst();
        chk("midrst_m_tvalid", m_axis.tvalid, 0);
        chk("midrst_s_tready", s_axis.tready, 0);
        chk("midrst_tlast", m_axis.tlast, 0);
        @(posedge clk);
        #1;
        m_axis.tready = 1'b1;
        n_last = 0;
        base_out = n_out;
        send_seq(6, 32'h300, 100);
        enable = 1'b0;
        wait_idle(100);
        chk("restart_out", n_out - base_out, 6);
        chk("restart_tlasts", n_last, 2);

        // Random valid/ready at 50%, 10000 beats
        @(posedge clk);
        #1;
        enable = 1'b1;
        base_out = n_out;
        acc_cnt = 0;
        t = 0;
        while (acc_cnt < 10000 && t < 50000) begin
            @(negedge clk);
            t++;
            acc = s_axis.tvalid && s_axis.tready;
            if (acc) acc_cnt++;
            @(posedge clk);
            #1;
            if (!s_axis.tvalid || acc) begin
                s_axis.tvalid = (acc_cnt < 10000) && ($urandom_range(0, 1) == 1);
                s_axis.tdata  = $urandom;
            end
            m_axis.tready = ($urandom_range(0, 1) == 1);
        end
        s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b1;
        enable = 1'b0;
        chk("rand_accepts", acc_cnt, 10000);
        wait_idle(200);
        chk("rand_out", n_out - base_out, 10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dut_stream_bridge.md
DUT_STREAM_BRIDGE -- requirements
Module: dut_stream_bridge

Interface
REQ-001 The module SHALL have parameter IN_W, default 16, DUT input sample width.
REQ-002 The module SHALL have parameter OUT_W, default 16, DUT output sample width (OUT_W <= AXIS_W).
REQ-003 The module SHALL have parameter AXIS_W, default 32, AXI-stream data width (multiple of 8, >= IN_W).
REQ-004 The module SHALL have parameter DUT_LAT, default 4, DUT pipeline latency in cycles (>= 1).
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 16, output buffer depth (power of 2, >= DUT_LAT+2).
REQ-006 The module SHALL have parameter FRAME_LEN, default 1024, output beats per frame (>= 1).
REQ-007 The module SHALL have a single clock, clk (input, 1): all logic is rising-edge on clk.
REQ-008 The module SHALL have rst (input, 1): synchronous, active-high reset.
REQ-009 The module SHALL have enable (input, 1): run request.
REQ-010 The module SHALL have s_axis_tdata/tvalid/tready (in AXIS_W / in 1 / out 1): sample stream from DMA MM2S.
REQ-011 The module SHALL have dut_din (out, IN_W) and dut_din_vld (out, 1): sample and strobe driven to DUT.
REQ-012 The module SHALL have dut_dout (in, OUT_W): DUT result, valid DUT_LAT cycles after the matching dut_din_vld.
REQ-013 The module SHALL have m_axis_tdata/tkeep/tlast/tvalid/tready (out AXIS_W / out AXIS_W/8 / out 1 / out 1 / in 1): result stream to DMA S2MM.
REQ-014 The module SHALL have busy (out, 1), high in RUN or DRAIN state.

Function
REQ-015 The module SHALL implement states IDLE, RUN and DRAIN: IDLE->RUN on enable=1; RUN->DRAIN on enable=0; DRAIN->IDLE when no sample is in flight and the FIFO is empty and the last beat has been accepted; DRAIN->RUN is not permitted.
REQ-016 The module SHALL drive s_axis_tready=1 only in RUN and only when (FIFO occupancy + in-flight count) < FIFO_DEPTH.
REQ-017 On each s_axis beat accepted (tvalid&tready), the module SHALL register dut_din=s_axis_tdata[IN_W-1:0] and pulse dut_din_vld high for exactly one cycle, one cycle after acceptance.
REQ-018 The module SHALL delay dut_din_vld by DUT_LAT cycles in a shift register; when the delayed strobe is high, it SHALL write dut_dout, extended to AXIS_W per REQ-027, into the FIFO that same cycle.
REQ-019 The credit rule of REQ-016 SHALL guarantee that a FIFO write never occurs while the FIFO is full; no sample is dropped under any tready pattern.
REQ-020 m_axis_tvalid SHALL be high whenever the FIFO is non-empty; m_axis_tdata SHALL be the FIFO head and SHALL hold stable while tvalid=1 and tready=0; tkeep SHALL be all ones.
REQ-021 A simultaneous FIFO write and read on a full or empty FIFO SHALL be handled correctly, with occupancy unchanged by a full/full simultaneous pair.
REQ-022 An output beat counter SHALL increment per accepted m_axis beat; tlast SHALL be 1 when the count equals FRAME_LEN-1, after which the counter wraps to 0.
REQ-023 In DRAIN, the final beat leaving the FIFO SHALL carry tlast=1 regardless of the count, and the counter SHALL clear to 0 on its acceptance.
REQ-024 Unaccepted s_axis data SHALL not be consumed; upstream tvalid without tready SHALL produce no strobe.

Reset
REQ-025 On rst=1 at a clk edge, the module SHALL enter IDLE, empty the FIFO, clear the delay line and beat counter, and drive s_axis_tready=0, dut_din_vld=0, dut_din=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0 from the next cycle.
REQ-026 On reset mid-frame, the module SHALL discard in-flight samples without emitting tlast; rst SHALL take priority over all other inputs.

Configuration
REQ-027 The module SHALL support macro DSB_SIGN_EXT_EN: when defined, dut_dout SHALL be sign-extended to AXIS_W; when undefined, it SHALL be zero-extended.

Verification
REQ-028 Defaults, enable=1, 8 beats 0x0001..0x0008, m tready=1 -> dut_din_vld pulses 1 cycle after each accept; loopback DUT output appears on m_axis in order, first beat DUT_LAT+2 cycles after first accept.
REQ-029 m tready held 0, s tvalid=1 continuously -> s tready falls after exactly FIFO_DEPTH accepts (16); release tready -> 16 beats out, none lost.
REQ-030 FRAME_LEN=4, 10 beats, then enable=0 -> tlast on beats 4, 8, 10; busy falls after beat 10; state IDLE.
REQ-031 dut_dout=0x8000: without DSB_SIGN_EXT_EN -> tdata 0x00008000; with DSB_SIGN_EXT_EN -> tdata 0xFFFF8000.
REQ-032 rst asserted with 3 samples in flight and 5 in the FIFO -> next cycle m tvalid=0, s tready=0; after re-enable, the counter restarts and the first tlast is at beat FRAME_LEN.
REQ-033 Random s tvalid/m tready at 50% each, 10000 beats -> output sequence equals the input sequence, with no tdata change while tvalid&!tready.
